// File: rtl/gf8_poly_reduce_if.sv
// gf8_poly_reduce_if: product-in / field-element-out handshake bundle for the GF(2^8) reducer.
interface gf8_poly_reduce_if;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_res;
  logic        busy;
  modport master (output in_valid, in_prod, out_ready, input in_ready, out_valid, out_res, busy);
  modport slave  (input in_valid, in_prod, out_ready, output in_ready, out_valid, out_res, busy);
endinterface

// File: rtl/gf8_poly_reduce.sv
// gf8_poly_reduce: bit-serial reduction of a 15-bit carry-less product modulo {1,POLY}, one bit per cycle.
module gf8_poly_reduce #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input logic clk,
  input logic rst,
  gf8_poly_reduce_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;
  state_t      state;
  logic [14:0] r;
  logic [14:0] r_next;
  logic [3:0]  k;
  logic [7:0]  res;
  logic [14:0] poly_full;
  assign poly_full = {6'b0, 1'b1, POLY};
  // k only takes 8..14 while REDUCE, so the shift stays within 0..6
  always_comb r_next = r[k] ? r ^ (poly_full << (k - 4'd8)) : r;
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_res   = res;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      r     <= '0;
      k     <= '0;
      res   <= '0;
    end else
      case (state)
        IDLE:
          if (bus.in_valid) begin
            r     <= bus.in_prod;
            k     <= 4'd14;
            state <= REDUCE;
          end
        REDUCE: begin
          r <= r_next;
          if (k == 4'd8) begin
            res   <= r_next[7:0];
            state <= DONE;
          end else
            k <= k - 4'd1;
        end
        DONE:    if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_gf8_poly_reduce.sv
// tb_gf8_poly_reduce: randomized self-checking bench against a power-table GF(2^8) model.
module tb_gf8_poly_reduce;
  localparam logic [7:0] POLY = 8'h1B;
  logic clk = 0;
  logic rst = 1;
  int   n_cmp = 0;
  int   n_err = 0;
  gf8_poly_reduce_if bus();
  gf8_poly_reduce #(.POLY(POLY)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // x^i mod P accumulated for every set bit of the product
  function automatic logic [7:0] ref_mod(input logic [14:0] p);
    logic [7:0] acc = 0;
    logic [7:0] pw = 8'h01;
    for (int i = 0; i < 15; i++) begin
      if (p[i]) acc ^= pw;
      pw = {pw[6:0], 1'b0} ^ (pw[7] ? POLY : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [14:0] clmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p = 0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    return p;
  endfunction

  task automatic do_op(input logic [14:0] p, output logic [7:0] res, output int lat);
    bus.in_valid = 1;
    bus.in_prod  = p;
    @(posedge clk); #1;
    bus.in_valid = 0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.out_res;
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.out_res !== 8'h00) begin n_err++; $display("FAIL reset_out_res got %h exp 00", bus.out_res); end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_vectors();
    logic [14:0] v [4] = '{15'h2B79, 15'h0053, 15'h0100, 15'h5555};
    logic [7:0]  e [4] = '{8'hC1, 8'h53, 8'h1B, 8'h13};
    logic [7:0]  res;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      do_op(v[i], res, lat);
      n_cmp++; if (res !== e[i]) begin n_err++; $display("FAIL vec_%h got %h exp %h", v[i], res, e[i]); end
      n_cmp++; if (lat != 7) begin n_err++; $display("FAIL lat_%h got %0d exp 7", v[i], lat); end
      n_cmp++; if (res !== ref_mod(v[i])) begin n_err++; $display("FAIL model_%h got %h exp %h", v[i], res, ref_mod(v[i])); end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, res;
    int         lat;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      do_op(clmul(a, b), res, lat);
      n_cmp++; if (res !== ref_mod(clmul(a, b)) || lat != 7) begin
        n_err++; $display("FAIL rand %h*%h got %h lat %0d exp %h lat 7", a, b, res, lat, ref_mod(clmul(a, b)));
      end
    end
  endtask

  task automatic test_backpressure();
    int wait_cyc = 0;
    bus.out_ready = 0;
    bus.in_valid = 1;
    bus.in_prod  = 15'h2B79;
    @(posedge clk); #1;
    bus.in_prod = 15'h1234;
    while (!bus.out_valid && wait_cyc < 20) begin
      n_cmp++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL bp_reduce in_ready %b busy %b exp 0 1", bus.in_ready, bus.busy); end
      @(posedge clk); #1;
      wait_cyc++;
    end
    n_cmp++; if (wait_cyc != 7) begin n_err++; $display("FAIL bp_latency got %0d exp 7", wait_cyc); end
    for (int i = 0; i < 20; i++) begin
      bus.in_prod = 15'(i * 37 + 5);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_res !== 8'hC1 || bus.in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold cyc %0d valid %b res %h ready %b exp 1 c1 0", i, bus.out_valid, bus.out_res, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release ready %b valid %b exp 1 0", bus.in_ready, bus.out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_no_capture ready %b exp 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] res;
    int         lat;
    bus.in_valid = 1;
    bus.in_prod  = 15'h5555;
    @(posedge clk); #1;
    bus.in_valid = 0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_res !== 8'h00) begin
      n_err++; $display("FAIL mid_reset ready %b valid %b res %h exp 1 0 00", bus.in_ready, bus.out_valid, bus.out_res);
    end
    @(posedge clk); #1;
    rst = 0;
    do_op(15'h2B79, res, lat);
    n_cmp++; if (res !== 8'hC1 || lat != 7) begin n_err++; $display("FAIL post_reset got %h lat %0d exp c1 lat 7", res, lat); end
  endtask

  task automatic test_back_to_back();
    logic [14:0] prods [10];
    logic [7:0]  exp_q [10];
    logic        rdy, ov;
    logic [7:0]  rv;
    int          sent = 0, got = 0, cyc = 0, last = -1;
    for (int i = 0; i < 10; i++) begin
      prods[i] = clmul(8'($urandom), 8'($urandom));
      exp_q[i] = ref_mod(prods[i]);
    end
    bus.out_ready = 1;
    while (got < 10 && cyc < 300) begin
      bus.in_valid = (sent < 10);
      bus.in_prod  = prods[sent < 10 ? sent : 0];
      rdy = bus.in_ready;
      ov  = bus.out_valid;
      rv  = bus.out_res;
      @(posedge clk); #1;
      cyc++;
      if (rdy && bus.in_valid) sent++;
      if (ov) begin
        n_cmp++; if (rv !== exp_q[got]) begin n_err++; $display("FAIL b2b_res %0d got %h exp %h", got, rv, exp_q[got]); end
        if (last >= 0) begin
          n_cmp++; if (cyc - last != 9) begin n_err++; $display("FAIL b2b_interval %0d got %0d exp 9", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
    end
    bus.in_valid = 0;
    n_cmp++; if (got != 10 || sent != 10) begin n_err++; $display("FAIL b2b_count got %0d sent %0d exp 10 10", got, sent); end
  endtask

  initial begin
    bus.in_valid  = 0;
    bus.in_prod   = '0;
    bus.out_ready = 1;
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gf8_poly_reduce.md
# gf8_poly_reduce

Sequential GF(2^8) modular reducer placed directly downstream of the 8-bit binary Karatsuba (carry-less) multiplier. It accepts the 15-bit carry-less product over a valid/ready handshake. It reduces the product modulo a fixed irreducible polynomial, one bit per cycle, from bit 14 down to bit 8. The 8-bit field element is presented on an output valid/ready handshake. Together with the multiplier it forms a complete GF(2^8) multiply path for the datapath.

## Interface

- POLY, 8'h1B: low 8 bits of the degree-8 reduction polynomial; x^8 is implicit, so the full polynomial is {1'b1, POLY}. The default is x^8+x^4+x^3+x+1. Irreducibility is the integrator's responsibility and is not checked.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_prod holds a product to reduce.
- in_ready  out  1  block can accept; equals (state == IDLE).
- in_prod  in  15  carry-less product, bits [14:0].
- out_valid  out  1  out_res holds a finished result.
- out_ready  in  1  consumer accepts out_res.
- out_res  out  8  reduced field element.
- busy  out  1  high in REDUCE or DONE.

## Operation

- Registers:
  - state: IDLE, REDUCE or DONE.
  - r[14:0]: working remainder.
  - k[3:0]: bit index.
  - out_res[7:0]: registered result.
- Reset (asynchronous, any state):
  - state=IDLE, r=0, k=0, out_res=0.
  - Outputs after reset: out_valid=0, busy=0, in_ready=1.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: r<=in_prod, k<=14, state<=REDUCE.
  - Otherwise hold.
- REDUCE (7 cycles, k=14..8):
  - If r[k]=1: r <= r ^ ({1'b1,POLY} << (k-8)). Otherwise r is unchanged.
  - If k==8: out_res <= next r[7:0], state<=DONE. Otherwise k<=k-1.
  - All 7 iterations always run; there is no early exit, so latency is data-independent.
- DONE:
  - out_valid=1. out_res is stable until the handshake completes.
  - On out_ready: state<=IDLE.
  - Without out_ready: hold indefinitely.
- in_valid outside IDLE is ignored; in_ready=0 there, and the upstream stage must hold its data.
- out_res keeps its last value after leaving DONE. It is only meaningful while out_valid=1.
- Arithmetic:
  - All operations are XOR in GF(2); there are no carries.
  - After iteration k, bit k of r is 0. After k=8, r[14:8]=0.
  - Inputs with in_prod[14:8]=0 pass through unchanged.
- Reset asserted mid-REDUCE or in DONE aborts the operation; the result is discarded and never presented.

## Timing

- Latency: the accept edge is E0. REDUCE occupies E1..E7, and out_valid rises after E7, i.e. 7 cycles after accept.
- Minimum initiation interval is 9 cycles: 1 IDLE accept cycle, 7 REDUCE cycles, and 1 DONE cycle with out_ready=1.
- in_ready and out_valid are decoded from the state register only, with no combinational path from in_valid or out_ready. busy = ~in_ready.
- The output handshake completes on the edge where out_valid & out_ready are both high. in_ready is high in the following cycle.
- Release of rst is assumed synchronized externally. The first accept can occur on the first edge after deassertion.

## Test plan

- AES vector:
  - Stimulus: in_prod=15'h2B79 (from 0x57·0x83), out_ready=1.
  - Response: out_res=8'hC1, with out_valid rising exactly 7 cycles after accept.
- Pass-through and single reduction:
  - in_prod=15'h0053 gives 8'h53.
  - in_prod=15'h0100 gives 8'h1B.
  - Both take a full 7-cycle latency.
- Worst case:
  - Stimulus: in_prod=15'h5555 (0xFF·0xFF).
  - Response: out_res=8'h13.
  - Then 1000 random 8-bit pairs, carry-less multiplied in the bench, compared against a reference model using POLY=8'h1B.
- Back-pressure and busy input:
  - Stimulus: hold out_ready=0 for 20 cycles in DONE, and pulse in_valid with different data during REDUCE and DONE.
  - Response: out_res and out_valid stay stable, in_ready stays 0, and the extra inputs are not captured.
  - After out_ready=1, in_ready=1 on the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst at REDUCE iteration k=11 (asynchronously, between edges).
  - Response: state=IDLE, out_valid=0, out_res=0 immediately.
  - A new in_prod=15'h2B79 afterwards still yields 8'hC1.
- Back-to-back throughput:
  - Stimulus: in_valid and out_ready held high with 10 queued products.
  - Response: one result every 9 cycles, all correct, with no drops or duplicates.
